// File: rtl/shift_reg_univ.sv
`default_nettype none
// ============================================================================
// Module      : shift_reg_univ
// Description : Universal shift register with hold, left/right shift, parallel
//               load and a shift counter that pulses done every WIDTH shifts.
//               Optional rotate is enabled by defining SR_ROTATE_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_reg_univ #(
    parameter int              WIDTH   = 8,
    parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}},
    parameter int              CW      = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             si_lsb,
    input  logic             si_msb,
    input  logic [WIDTH-1:0] d,
`ifdef SR_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] q,
    output logic             so_msb,
    output logic             so_lsb,
    output logic [CW-1:0]    cnt,
    output logic             done
);

    localparam logic [1:0]    c_MODE_HOLD = 2'b00;
    localparam logic [1:0]    c_MODE_SHL  = 2'b01;
    localparam logic [1:0]    c_MODE_SHR  = 2'b10;
    localparam logic [1:0]    c_MODE_LOAD = 2'b11;
    localparam logic [CW-1:0] c_CNT_LAST  = CW'(WIDTH - 1);

    logic             w_rot;
    logic             w_fill_l;
    logic             w_fill_r;
    logic [WIDTH-1:0] w_shl;
    logic [WIDTH-1:0] w_shr;
    logic             w_wrap;

`ifdef SR_ROTATE_EN
    assign w_rot = rot;
`else
    assign w_rot = 1'b0;
`endif

    always_comb begin
        w_fill_l = w_rot ? q[WIDTH-1] : si_lsb;
        w_fill_r = w_rot ? q[0]       : si_msb;
        w_shl    = {q[WIDTH-2:0], w_fill_l};
        w_shr    = {w_fill_r, q[WIDTH-1:1]};
        w_wrap   = (cnt == c_CNT_LAST);
    end

    assign so_msb = q[WIDTH-1];
    assign so_lsb = q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= RST_VAL;
            cnt  <= '0;
            done <= 1'b0;
        end else begin
            case (mode)
                c_MODE_LOAD: begin
                    q    <= d;
                    cnt  <= '0;
                    done <= 1'b0;
                end
                c_MODE_SHL, c_MODE_SHR: begin
                    q <= (mode == c_MODE_SHL) ? w_shl : w_shr;
                    // Wrap on the WIDTH-th shift so cnt never reaches WIDTH.
                    if (w_wrap) begin
                        cnt  <= '0;
                        done <= 1'b1;
                    end else begin
                        cnt  <= cnt + CW'(1);
                        done <= 1'b0;
                    end
                end
                c_MODE_HOLD: done <= 1'b0;
                default:     done <= 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/shift_reg_univ.md
# shift_reg_univ

Parametrised universal shift register: successor to the single-direction serial-in/serial-out left shifter. Adds configurable width, bidirectional shift, parallel load, hold, a shift counter with frame-complete pulse, and optional rotate. Used as the generic serialiser/deserialiser building block in the shift-register library.

## Interface
- WIDTH, 8, register width in bits; legal range 2..64.
- RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset.
- CW, $clog2(WIDTH+1), counter width (derived; do not override).

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- mode  input  2  00 hold, 01 shift left, 10 shift right, 11 parallel load.
- si_lsb  input  1  serial input entering bit 0 on shift left.
- si_msb  input  1  serial input entering bit WIDTH-1 on shift right.
- d  input  WIDTH  parallel load data.
- rot  input  1  rotate select; present only when SR_ROTATE_EN is defined.
- q  output  WIDTH  register contents.
- so_msb  output  1  q[WIDTH-1]; serial out for left shift.
- so_lsb  output  1  q[0]; serial out for right shift.
- cnt  output  CW  shifts completed since last load/reset/wrap.
- done  output  1  one-cycle pulse: WIDTH-th shift completed.

One clock; reset is asynchronous and active-high (ports clk and rst).

## Operation
- Reset (rst=1, any time, no clock needed): q=RST_VAL, cnt=0, done=0; so_msb/so_lsb follow q. Held while rst=1.
- mode 00 hold: q, cnt unchanged; done=0.
- mode 01 shift left: q <= {q[WIDTH-2:0], si_lsb}; MSB discarded.
- mode 10 shift right: q <= {si_msb, q[WIDTH-1:1]}; LSB discarded.
- mode 11 load: q <= d; cnt <= 0; done <= 0.
- Counter: each shift (01 or 10, either direction, mixed allowed) increments cnt. On the shift where cnt==WIDTH-1: cnt <= 0, done <= 1. Any other edge: done <= 0. cnt never reaches WIDTH.
- Load always wins over counting; load on the edge that would have wrapped gives cnt=0, done=0.
- so_msb and so_lsb are wires from q; no extra register.
- Unknown/X mode treated as hold in simulation is not required; bench drives only legal values.

## Timing
- All outputs registered (so_* via q); q, cnt, done update on the rising clk edge following the controlling inputs; latency one cycle.
- Serial data: bit presented on si_lsb at edge k appears at so_msb after WIDTH edges of continuous left shift (symmetric for right).
- done high for exactly one cycle per WIDTH shifts; back-to-back frames give done every WIDTH shift cycles with no gap.
- Hold cycles inside a frame stretch the frame; they neither reset cnt nor assert done.
- Reset asserted mid-frame aborts immediately; deassertion is synchronised externally; first edge after release performs the commanded mode.

## Configuration
- SR_ROTATE_EN defined: rot port exists. With rot=1 in mode 01, q <= {q[WIDTH-2:0], q[WIDTH-1]}; in mode 10, q <= {q[0], q[WIDTH-1:1]}; si_* ignored; rotates count toward cnt/done as shifts. rot ignored in modes 00/11.
- SR_ROTATE_EN undefined: rot port absent; shifts always take serial inputs.

## Test plan
- Reset (WIDTH=4, RST_VAL=0): assert rst between edges -> q=0000, cnt=0, done=0, so_msb=so_lsb=0 immediately.
- Left shift from 0000, si_lsb=1,0,1,1 -> q=0001,0010,0101,1011; cnt=1,2,3,0; done=1 only after 4th edge, so_msb=1.
- Load d=1001, then mode 10 with si_msb=0 twice -> q=1001,0100,0010; cnt=0,1,2; then load d=1111 -> q=1111, cnt=0.
- Shift left 2, hold 3 cycles, shift right 2 -> cnt 1,2,2,2,2,3,0; done pulses once on the final edge only.
- Assert rst mid-frame (cnt=2, q=0110) -> q=0000, cnt=0 without clock; first edge after release with mode 01, si_lsb=1 -> q=0001, cnt=1.
- SR_ROTATE_EN, rot=1: load 1001, rotate left x4 -> 0011,0110,1100,1001; done=1 on 4th; rotate right from 1001 -> 1100.
